// File: rtl/img_cap_pkg.sv
// Shared types and constants for the image capture write path.
// Pixel/memory widths, pad byte and the write-stage state encoding.
package img_cap_pkg;

  localparam int PIX_W  = 24;
  localparam int MEM_DW = 32;
  localparam int CNT_W  = 24;

  localparam logic [MEM_DW-PIX_W-1:0] PIX_PAD = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } wr_stage_state_t;

endpackage

// File: rtl/pix_sync_fifo.sv
// Show-ahead synchronous FIFO for the pixel write path.
// Pointers carry one extra MSB so full and empty are distinguishable.
module pix_sync_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         CLOCK_125_p,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q;
  logic [AW:0]  rp_q;
  logic         wr_en;
  logic         rd_en;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  // A full FIFO still takes a push when the head leaves this cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign dout = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge CLOCK_125_p) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr_en) wp_q <= wp_q + (AW+1)'(1);
      if (rd_en) rp_q <= rp_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLOCK_125_p) begin
    if (wr_en) mem_q[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/img_wr_stage.sv
// Frames the camera pixel stream into fixed-length write bursts
// for memory port 0, with drop and sync error reporting.
module img_wr_stage
  import img_cap_pkg::*;
#(
  parameter int FRAME_PIX  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              CLOCK_125_p,
  input  logic              reset,
  input  logic              sof,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              wr_rdy,
  output logic              wr_req,
  output logic [MEM_DW-1:0] wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              ovf,
  output logic              sync_err,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam logic [CNT_W-1:0] FP = CNT_W'(FRAME_PIX);

  wr_stage_state_t  state_q;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             ovf_q;
  logic             sync_err_q;
  logic             done_q;

  logic             take;
  logic             push;
  logic             drop;
  logic             pop;
  logic             full;
  logic             empty;
  logic             start;
  logic [PIX_W-1:0] head;

  pix_sync_fifo #(
    .W     (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_125_p (CLOCK_125_p),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .din         (pix_data),
    .dout        (head),
    .full        (full),
    .empty       (empty)
  );

  assign pop   = !empty && wr_rdy;
  assign start = (state_q == IDLE) && sof;

  always_comb begin
    take = 1'b0;
    unique case (state_q)
      IDLE:    take = sof && pix_valid;
      ACTIVE:  take = pix_valid;
      default: take = 1'b0;
    endcase
    push = take && (!full || pop);
    drop = take && !push;
  end

  // Dropped pixels still advance the frame so its length is preserved.
  always_comb begin
    acc_d    = acc_q + CNT_W'(take);
    drop_d   = drop_q + CNT_W'(drop);
    wr_cnt_d = wr_cnt_q + CNT_W'(pop);
    if (start) begin
      acc_d    = CNT_W'(take);
      drop_d   = '0;
      wr_cnt_d = '0;
    end
  end

  always_ff @(posedge CLOCK_125_p) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      drop_q     <= '0;
      wr_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      sync_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      drop_q   <= drop_d;
      wr_cnt_q <= wr_cnt_d;
      done_q   <= 1'b0;
      if (drop) ovf_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (sof) begin
            state_q <= (acc_d == FP) ? FLUSH : ACTIVE;
          end
        end
        ACTIVE: begin
          if (sof) sync_err_q <= 1'b1;
          if (acc_d == FP) state_q <= FLUSH;
        end
        FLUSH: begin
          if (sof) sync_err_q <= 1'b1;
          // Every kept pixel has left once the count hits this target.
          if (wr_cnt_d == FP - drop_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_req     = !empty;
  assign wr_data    = empty ? '0 : {PIX_PAD, head};
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);
  assign ovf        = ovf_q;
  assign sync_err   = sync_err_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_img_wr_stage.sv
// Scoreboard bench for img_wr_stage: directed frames, a negedge
// monitor checks every transfer against queued expected words.
module tb_img_wr_stage;

  logic        clk;
  logic        reset;
  logic        sof;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        wr_rdy;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        frame_done;
  logic        busy;
  logic        ovf;
  logic        sync_err;
  logic [23:0] wr_cnt;

  int          n_chk;
  int          n_fail;
  int          done_cnt;
  int          cyc;
  int          last_xfer;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [31:0] exp_q [$];

  img_wr_stage #(
    .FRAME_PIX  (16),
    .FIFO_DEPTH (8)
  ) dut (
    .CLOCK_125_p (clk),
    .reset       (reset),
    .sof         (sof),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .wr_rdy      (wr_rdy),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .busy        (busy),
    .ovf         (ovf),
    .sync_err    (sync_err),
    .wr_cnt      (wr_cnt)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [23:0] d,
                    input logic s,
                    input logic r);
    sof       = s;
    pix_valid = 1'b1;
    pix_data  = d;
    wr_rdy    = r;
    tick();
    sof       = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic sof_only();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int exp_wr);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cnt != d0), 32'd1);
    chk("done_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (4) tick();
    chk("done_once", 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_req"}, 32'(wr_req), 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_req", 32'(wr_req), 32'd1);
        chk("stall_data", wr_data, prev_data);
      end
      if (wr_req && wr_rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_xfer: got %h required none",
                   wr_data);
        end else begin
          chk("wr_data", wr_data, exp_q.pop_front());
        end
        last_xfer = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_timing", 32'(cyc), 32'(last_xfer + 1));
      end
      prev_stall = wr_req && !wr_rdy;
      prev_data  = wr_data;
    end
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    done_cnt   = 0;
    cyc        = 0;
    last_xfer  = -10;
    prev_stall = 1'b0;
    prev_data  = '0;
    reset      = 1'b1;
    sof        = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    wr_rdy     = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // basic frame
    wr_rdy = 1'b1;
    sof_only();
    chk("basic_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(32'h00FFFFFF);
      px(24'hFFFFFF, 1'b0, 1'b1);
    end
    wait_done(64, 16);
    chk("basic_ovf", 32'(ovf), 32'd0);

    // backpressure, sof with first pixel, full with pop
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(32'(k));
      px(24'(k), k == 0, k >= 8);
      if (k == 7) begin
        chk("bp_req", 32'(wr_req), 32'd1);
        chk("bp_head", wr_data, 32'h0);
      end
      if (k == 8) chk("bp_fullpop_ovf", 32'(ovf), 32'd0);
    end
    wait_done(64, 16);
    chk("bp_ovf", 32'(ovf), 32'd0);

    // sync: idle pixels ignored, second sof mid-frame
    for (int k = 0; k < 3; k++) px(24'hABCDEF, 1'b0, 1'b1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ovf", 32'(ovf), 32'd0);
    chk("idle_req", 32'(wr_req), 32'd0);
    sof_only();
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(32'h00200000 + 32'(k));
      px(24'h200000 + 24'(k), k == 5, 1'b1);
      if (k == 4) chk("sync_pre", 32'(sync_err), 32'd0);
    end
    chk("sync_err", 32'(sync_err), 32'd1);
    wait_done(64, 16);
    sof_only();
    chk("new_frame_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("new_frame_busy", 32'(busy), 32'd1);
    chk("sync_sticky", 32'(sync_err), 32'd1);
    do_reset();
    chk("sync_clear", 32'(sync_err), 32'd0);

    // overflow: no ready for the whole frame
    sof_only();
    for (int k = 0; k < 16; k++) begin
      if (k < 8) exp_q.push_back(32'h00300000 + 32'(k));
      px(24'h300000 + 24'(k), 1'b0, 1'b0);
    end
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_wr_cnt", 32'(wr_cnt), 32'd0);
    wr_rdy = 1'b1;
    wait_done(64, 8);
    do_reset();

    // full FIFO: one pop-with-push keeps it full
    wr_rdy = 1'b0;
    sof_only();
    for (int k = 0; k < 16; k++) begin
      if (k <= 8) exp_q.push_back(32'h00400000 + 32'(k));
      px(24'h400000 + 24'(k), 1'b0, k == 8);
      if (k == 8) chk("fp_no_drop", 32'(ovf), 32'd0);
      if (k == 9) chk("fp_still_full", 32'(ovf), 32'd1);
    end
    wr_rdy = 1'b1;
    wait_done(64, 9);

    // reset mid-frame after 6 transfers
    wr_rdy = 1'b0;
    sof_only();
    for (int k = 0; k < 8; k++) begin
      if (k < 6) exp_q.push_back(32'h00500000 + 32'(k));
      px(24'h500000 + 24'(k), 1'b0, 1'b0);
    end
    wr_rdy = 1'b1;
    repeat (6) tick();
    reset  = 1'b1;
    wr_rdy = 1'b0;
    tick();
    chk_reset_vals("midrst");
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    begin
      int d0;
      d0     = done_cnt;
      wr_rdy = 1'b1;
      repeat (10) tick();
      chk("midrst_no_done", 32'(done_cnt), 32'(d0));
      chk("midrst_req", 32'(wr_req), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/img_wr_stage.md
# img_wr_stage

Upstream write-feed stage for the stereoscopic capture path. It accepts a 24-bit pixel stream from the camera capture logic, buffers it in a small synchronous FIFO, and presents 32-bit write words with a request/ready handshake to the frame buffer address generator and memory interface port 0. It frames each image: it begins at a start-of-frame strobe, writes exactly `FRAME_PIX` words, then signals completion. It also reports drop and sync errors.

## Interface
- `FRAME_PIX`, 16: pixels per frame; range 1 to 2^24-1.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CLOCK_125_p`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sof`  in  1  start-of-frame strobe, one cycle.
- `pix_valid`  in  1  `pix_data` is valid this cycle.
- `pix_data`  in  24  RGB pixel.
- `wr_rdy`  in  1  downstream can accept a word this cycle.
- `wr_req`  out  1  `wr_data` is valid; a transfer occurs when `wr_req && wr_rdy`.
- `wr_data`  out  32  `{8'h00, pixel}`.
- `frame_done`  out  1  one-cycle pulse after the last word of a frame transfers.
- `busy`  out  1  state is not IDLE.
- `ovf`  out  1  sticky: a pixel was dropped.
- `sync_err`  out  1  sticky: `sof` arrived while not IDLE.
- `wr_cnt`  out  24  words transferred in the current frame.

## Operation
- States: IDLE, ACTIVE, FLUSH.
- IDLE:
  - Pixels are discarded; they do not set `ovf`.
  - `sof` → ACTIVE; clear `wr_cnt` and the accepted-pixel counter `acc_cnt`.
- If `sof` and `pix_valid` occur in the same cycle in IDLE, that pixel is the first pixel of the frame.
- ACTIVE:
  - A pixel is pushed when `pix_valid` is high and the FIFO is not full, or when it is full but a pop occurs in the same cycle.
  - Otherwise the pixel is dropped and `ovf` is set. A dropped pixel still counts toward `acc_cnt`, so frame length is preserved.
  - When `acc_cnt` reaches `FRAME_PIX` → FLUSH.
- FLUSH:
  - `pix_valid` is ignored.
  - When the FIFO is empty and `wr_cnt` equals (`FRAME_PIX` − dropped count) → IDLE, with `frame_done` pulsed in the cycle IDLE is entered.
- `wr_cnt` increments on each transfer.
- `sof` while in ACTIVE or FLUSH sets `sync_err` and is otherwise ignored.
- `ovf` and `sync_err` clear only on `reset`.
- FIFO:
  - Show-ahead: the head word drives `wr_data` directly.
  - `wr_req` equals FIFO-not-empty.
  - Pointers are log2(`FIFO_DEPTH`)+1 bits wide, with the extra MSB used for full/empty detection.
  - Pointers wrap modulo 2·`FIFO_DEPTH`.
- `wr_data` holds its value while `wr_req && !wr_rdy`. `wr_req` never deasserts without a transfer.

## Timing
- Reset values: state IDLE, FIFO empty, `wr_req`=0, `wr_data`=0, `frame_done`=0, `busy`=0, `ovf`=0, `sync_err`=0, `wr_cnt`=0.
- Latency: a pixel pushed in cycle N gives `wr_req`=1 in cycle N+1 if the FIFO was empty.
- Throughput: 1 word per cycle when `wr_rdy` is held high.
- `frame_done` is asserted the cycle after the final transfer. `busy` falls in the same cycle.
- `reset` mid-frame aborts immediately: the FIFO is emptied and no `frame_done` is issued.
- `FRAME_PIX`=1: ACTIVE lasts until the first pixel; FLUSH follows immediately.

## Structure
- Shared package `img_cap_pkg` contains:
  - `PIX_W`=24 and `MEM_DW`=32.
  - The state typedef `wr_stage_state_t` (IDLE, ACTIVE, FLUSH).
  - The pad constant `PIX_PAD`=8'h00.
- Sub-module `pix_sync_fifo`:
  - Parameterized width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - Simultaneous push and pop when full is legal.
- The top contains the FSM, counters, and sticky flags.

## Test plan
- Basic frame: `FRAME_PIX`=16, `sof` then 16 consecutive pixels 24'hFFFFFF, `wr_rdy`=1. Expect:
  - 16 transfers of 32'h00FFFFFF.
  - `wr_cnt`=16.
  - `frame_done` exactly once, one cycle after the last transfer.
  - `ovf`=0.
- Backpressure: `wr_rdy`=0 for the first 8 pixels, then 1. Expect:
  - The FIFO fills to 8 with no drop.
  - `wr_data` stable while stalled.
  - All 16 words arrive in order, pixel k = 24'h000000+k.
- Overflow: `wr_rdy`=0 throughout the entire 16-pixel frame, released afterwards. Expect:
  - `ovf`=1.
  - Pixels 0–7 are written; 8–15 are dropped.
  - `frame_done` after 8 transfers.
- Full with simultaneous pop: FIFO full, `wr_rdy`=1 and `pix_valid`=1 in the same cycle. Expect the push to be accepted, the count to stay at 8, and `ovf`=0.
- Sync: pixels before `sof` are ignored; a second `sof` at pixel 5. Expect:
  - `sync_err`=1.
  - The frame still completes with 16 words.
  - A `sof` after `frame_done` starts a new frame with `wr_cnt`=0.
- Reset mid-frame: assert `reset` after 6 transfers. Expect all outputs at reset values the next cycle and no `frame_done`.
